ahb_si_resp_demux_master: RTL and testbench

AHB_SI_RESP_DEMUX_MASTER -- requirements
Module: ahb_si_resp_demux_master

---
 rtl/ahb_si_resp_demux_master_if.sv | 25 ++
 rtl/ahb_si_resp_demux_master.sv | 114 +++++++++++
 tb/tb_ahb_si_resp_demux_master.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/ahb_si_resp_demux_master_if.sv
// Response-demux bus bundle between an AHB master port and its slave channels.
// The demux itself uses modport slave; the driving side (master/decoder/slaves) uses modport master.
interface ahb_si_resp_demux_master_if #(
  parameter int unsigned CHANNEL_NUM = 3,
  parameter int unsigned PAY_LOAD    = 33
);
  logic [CHANNEL_NUM-1:0]               sel_addr;
  logic [1:0]                           htrans;
  logic [CHANNEL_NUM-1:0][PAY_LOAD-1:0] payload_in;
  logic [CHANNEL_NUM-1:0]               hreadyout_in;
  logic [31:0]                          hrdata_out;
  logic                                 hresp_out;
  logic                                 hready_out;
  logic [CHANNEL_NUM-1:0]               sel_data;

  modport slave (
    input  sel_addr, htrans, payload_in, hreadyout_in,
    output hrdata_out, hresp_out, hready_out, sel_data
  );

  modport master (
    output sel_addr, htrans, payload_in, hreadyout_in,
    input  hrdata_out, hresp_out, hready_out, sel_data
  );
endinterface

// File: rtl/ahb_si_resp_demux_master.sv
// AHB slave-response demux for one master: registered data-phase select plus optional
// default-slave ERROR responder for unmapped active transfers, enabled by `define DEFAULT_SLAVE_EN.
module ahb_si_resp_demux_master #(
  parameter int unsigned CHANNEL_NUM = 3,
  parameter int unsigned PAY_LOAD    = 33
) (
  input logic                            HCLK,
  input logic                            HRESETn,
  ahb_si_resp_demux_master_if.slave      bus
);

  logic [CHANNEL_NUM-1:0] r_sel_data;
  logic                   w_accept;
  logic                   w_onehot;
  logic [31:0]            w_mux_data;
  logic                   w_mux_resp;
  logic                   w_mux_ready;
  logic                   w_dflt_ready;
  logic                   w_dflt_resp;

  assign w_accept = bus.hready_out;
  assign w_onehot = $onehot(bus.sel_addr);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_sel_data <= '0;
    end else if (w_accept) begin
      r_sel_data <= w_onehot ? bus.sel_addr : '0;
    end
  end

  // r_sel_data is at most one-hot, so an AND-OR mux never merges two channels.
  always_comb begin
    w_mux_data  = '0;
    w_mux_resp  = 1'b0;
    w_mux_ready = 1'b0;
    for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
      if (r_sel_data[i]) begin
        w_mux_data  = w_mux_data | bus.payload_in[i][31:0];
        w_mux_resp  = w_mux_resp | bus.payload_in[i][32];
        w_mux_ready = w_mux_ready | bus.hreadyout_in[i];
      end
    end
  end

`ifdef DEFAULT_SLAVE_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_t;

  state_t r_state;
  logic   r_dflt_ready;
  logic   r_dflt_resp;
  logic   w_active;
  logic   w_unmapped_active;

  assign w_active          = (bus.htrans == 2'b10) || (bus.htrans == 2'b11);
  assign w_unmapped_active = w_accept && w_active && !w_onehot;

  // Default-slave response is registered alongside the state so it is glitch-free.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state      <= ST_IDLE;
      r_dflt_ready <= 1'b1;
      r_dflt_resp  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_unmapped_active) begin
            r_state      <= ST_ERR1;
            r_dflt_ready <= 1'b0;
            r_dflt_resp  <= 1'b1;
          end
        end
        ST_ERR1: begin
          r_state      <= ST_ERR2;
          r_dflt_ready <= 1'b1;
          r_dflt_resp  <= 1'b1;
        end
        ST_ERR2: begin
          if (w_unmapped_active) begin
            r_state      <= ST_ERR1;
            r_dflt_ready <= 1'b0;
            r_dflt_resp  <= 1'b1;
          end else begin
            r_state      <= ST_IDLE;
            r_dflt_ready <= 1'b1;
            r_dflt_resp  <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_dflt_ready <= 1'b1;
          r_dflt_resp  <= 1'b0;
        end
      endcase
    end
  end

  assign w_dflt_ready = r_dflt_ready;
  assign w_dflt_resp  = r_dflt_resp;
`else
  assign w_dflt_ready = 1'b1;
  assign w_dflt_resp  = 1'b0;
`endif

  assign bus.hrdata_out = (|r_sel_data) ? w_mux_data  : '0;
  assign bus.hresp_out  = (|r_sel_data) ? w_mux_resp  : w_dflt_resp;
  assign bus.hready_out = (|r_sel_data) ? w_mux_ready : w_dflt_ready;
  assign bus.sel_data   = r_sel_data;

endmodule

// File: tb/tb_ahb_si_resp_demux_master.sv
// Directed self-checking bench for ahb_si_resp_demux_master; expectations follow DEFAULT_SLAVE_EN.
module tb_ahb_si_resp_demux_master;

`ifdef DEFAULT_SLAVE_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic HCLK;
  logic HRESETn;
  int   n_tests = 0;
  int   n_fail  = 0;

  ahb_si_resp_demux_master_if #(.CHANNEL_NUM(3), .PAY_LOAD(33)) bus ();

  ahb_si_resp_demux_master #(.CHANNEL_NUM(3), .PAY_LOAD(33)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus.slave)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [2:0] sel, input logic rdy,
                           input logic rsp, input logic [31:0] data);
    #1;
    chk({tag, ".sel"},   {29'd0, bus.sel_data}, {29'd0, sel});
    chk({tag, ".ready"}, {31'd0, bus.hready_out}, {31'd0, rdy});
    chk({tag, ".resp"},  {31'd0, bus.hresp_out}, {31'd0, rsp});
    chk({tag, ".data"},  bus.hrdata_out, data);
  endtask

  task automatic next_edge();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    HRESETn          = 1'b0;
    bus.sel_addr     = 3'b000;
    bus.htrans       = 2'b00;
    bus.hreadyout_in = 3'b111;
    bus.payload_in[0] = {1'b0, 32'hA0A0_0000};
    bus.payload_in[1] = {1'b0, 32'h1111_1111};
    bus.payload_in[2] = {1'b0, 32'hC2C2_C2C2};
    #12;
    check_out("reset", 3'b000, 1'b1, 1'b0, 32'h0);

    // Wait-stated NONSEQ to slave 1; a changing address must not disturb the held select.
    @(negedge HCLK);
    HRESETn      = 1'b1;
    bus.sel_addr = 3'b010;
    bus.htrans   = 2'b10;
    next_edge();
    bus.hreadyout_in[1] = 1'b0;
    bus.sel_addr        = 3'b001;
    check_out("wait1", 3'b010, 1'b0, 1'b0, 32'h1111_1111);
    next_edge();
    check_out("wait2", 3'b010, 1'b0, 1'b0, 32'h1111_1111);
    bus.hreadyout_in[1] = 1'b1;
    bus.payload_in[1]   = {1'b0, 32'h1234_5678};
    check_out("wdone", 3'b010, 1'b1, 1'b0, 32'h1234_5678);

    // Back-to-back zero-wait transfers to slaves 0, 2, 1.
    next_edge();
    bus.sel_addr = 3'b100;
    check_out("b2b0", 3'b001, 1'b1, 1'b0, 32'hA0A0_0000);
    next_edge();
    bus.sel_addr = 3'b010;
    check_out("b2b2", 3'b100, 1'b1, 1'b0, 32'hC2C2_C2C2);
    next_edge();
    bus.sel_addr = 3'b000;
    bus.htrans   = 2'b00;
    check_out("b2b1", 3'b010, 1'b1, 1'b0, 32'h1234_5678);

    // Unmapped IDLE / BUSY transfers get a plain OKAY.
    next_edge();
    bus.sel_addr = 3'b011;
    bus.htrans   = 2'b01;
    check_out("idle_unmap", 3'b000, 1'b1, 1'b0, 32'h0);
    next_edge();
    bus.sel_addr = 3'b000;
    bus.htrans   = 2'b10;
    check_out("busy_unmap", 3'b000, 1'b1, 1'b0, 32'h0);

    // Unmapped NONSEQ.
    next_edge();
    bus.htrans = 2'b00;
    check_out("err1", 3'b000, ~DS, DS, 32'h0);
    next_edge();
    check_out("err2", 3'b000, 1'b1, DS, 32'h0);
    next_edge();
    bus.sel_addr = 3'b011;
    bus.htrans   = 2'b11;
    check_out("err_done", 3'b000, 1'b1, 1'b0, 32'h0);

    // Multi-hot SEQ, then a second unmapped NONSEQ accepted in ERR2.
    next_edge();
    bus.sel_addr = 3'b000;
    bus.htrans   = 2'b10;
    check_out("bb_err1a", 3'b000, ~DS, DS, 32'h0);
    next_edge();
    check_out("bb_err2a", 3'b000, 1'b1, DS, 32'h0);
    next_edge();
    bus.htrans = 2'b00;
    check_out("bb_err1b", 3'b000, ~DS, DS, 32'h0);
    next_edge();
    check_out("bb_err2b", 3'b000, 1'b1, DS, 32'h0);
    next_edge();
    bus.htrans = 2'b10;
    check_out("bb_idle", 3'b000, 1'b1, 1'b0, 32'h0);

    // Asynchronous reset in the middle of ERR1, then recovery to slave 2.
    next_edge();
    check_out("pre_rst", 3'b000, ~DS, DS, 32'h0);
    HRESETn = 1'b0;
    check_out("mid_rst", 3'b000, 1'b1, 1'b0, 32'h0);
    bus.sel_addr      = 3'b100;
    bus.payload_in[2] = {1'b1, 32'h5A5A_0002};
    @(negedge HCLK);
    HRESETn = 1'b1;
    next_edge();
    bus.sel_addr = 3'b000;
    bus.htrans   = 2'b00;
    check_out("post_rst", 3'b100, 1'b1, 1'b1, 32'h5A5A_0002);
    next_edge();
    check_out("final_idle", 3'b000, 1'b1, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
